// File: rtl/common_frame_pkg.sv
// rtl/common_frame_pkg.sv - shared types and helpers for the common-frame header generator
package common_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } state_t;

  // Beat counter must hold values 0..head_bytes
  function automatic int cnt_width(input int head_bytes);
    return $clog2(head_bytes + 1);
  endfunction

endpackage

// File: rtl/axi_stream_inf.sv
// rtl/axi_stream_inf.sv - minimal AXI-stream bundle shared by frame generator and parser
interface axi_stream_inf #(
  parameter int DSIZE = 8
) ();

  localparam int KSIZE = (DSIZE + 7) / 8;

  logic [DSIZE-1:0] axis_tdata;
  logic             axis_tvalid;
  logic             axis_tready;
  logic             axis_tlast;
  logic [KSIZE-1:0] axis_tkeep;
  logic             axis_tuser;

  modport master (
    output axis_tdata,
    output axis_tvalid,
    input  axis_tready,
    output axis_tlast,
    output axis_tkeep,
    output axis_tuser
  );

  modport slaver (
    input  axis_tdata,
    input  axis_tvalid,
    output axis_tready,
    input  axis_tlast,
    input  axis_tkeep,
    input  axis_tuser
  );

endinterface

// File: rtl/gen_common_frame_head.sv
// rtl/gen_common_frame_head.sv - emits a latched fixed-length header then forwards one payload packet
module gen_common_frame_head
  import common_frame_pkg::*;
#(
  parameter int HEAD_BYTES  = 20,
  parameter int DSIZE       = 8,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic [HEAD_BYTES*DSIZE-1:0] head_data,
  input  logic                        head_valid,
  output logic                        head_ready,
  output logic                        busy,
  output logic [FRAME_CNT_W-1:0]      frame_cnt,
  axi_stream_inf.slaver               cm_tb_s,
  axi_stream_inf.master               cm_tb_m
);

  localparam int HW    = HEAD_BYTES * DSIZE;
  localparam int CNT_W = cnt_width(HEAD_BYTES);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(HEAD_BYTES - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [HW-1:0]          shreg_q, shreg_d;
  logic                   head_ready_q, head_ready_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Next-state logic: header latch, header shift-out, payload tlast detection
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    head_ready_d = head_ready_q;
    frame_cnt_d  = frame_cnt_q;
    case (state_q)
      IDLE: begin
        // head_ready rises one cycle after reset and stays up until a header is taken
        head_ready_d = 1'b1;
        if (head_valid && head_ready_q) begin
          shreg_d      = head_data;
          cnt_d        = '0;
          head_ready_d = 1'b0;
          state_d      = HEAD;
        end
      end
      HEAD: begin
        if (cm_tb_m.axis_tready) begin
          shreg_d = shreg_q << DSIZE;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = BODY;
          end
        end
      end
      BODY: begin
        if (cm_tb_s.axis_tvalid && cm_tb_m.axis_tready && cm_tb_s.axis_tlast) begin
          // Ready is raised together with the return to IDLE so the next header
          // is accepted on the very next cycle
          state_d      = IDLE;
          head_ready_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
        end
      end
      default: begin
        state_d      = IDLE;
        head_ready_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      head_ready_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      head_ready_q <= head_ready_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Stream steering: header beats come straight from flops, payload is a zero-latency pass-through
  always_comb begin
    cm_tb_m.axis_tvalid = 1'b0;
    cm_tb_m.axis_tdata  = '0;
    cm_tb_m.axis_tlast  = 1'b0;
    cm_tb_m.axis_tkeep  = '0;
    cm_tb_m.axis_tuser  = 1'b0;
    cm_tb_s.axis_tready = 1'b0;
    case (state_q)
      HEAD: begin
        cm_tb_m.axis_tvalid = 1'b1;
        cm_tb_m.axis_tdata  = shreg_q[HW-1 -: DSIZE];
        cm_tb_m.axis_tkeep  = '1;
      end
      BODY: begin
        cm_tb_m.axis_tvalid = cm_tb_s.axis_tvalid;
        cm_tb_m.axis_tdata  = cm_tb_s.axis_tdata;
        cm_tb_m.axis_tlast  = cm_tb_s.axis_tlast;
        cm_tb_m.axis_tkeep  = cm_tb_s.axis_tkeep;
        cm_tb_m.axis_tuser  = cm_tb_s.axis_tuser;
        cm_tb_s.axis_tready = cm_tb_m.axis_tready;
      end
      default: begin
        cm_tb_s.axis_tready = 1'b0;
      end
    endcase
  end

  assign head_ready = head_ready_q;
  assign busy       = (state_q != IDLE);
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_gen_common_frame_head.sv
// tb/tb_gen_common_frame_head.sv - scoreboard bench for gen_common_frame_head
module tb_gen_common_frame_head;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         rst_n;
  logic [159:0] head_data0;
  logic         head_valid0, head_ready0, busy0;
  logic [15:0]  frame_cnt0;
  logic [7:0]   head_data1;
  logic         head_valid1, head_ready1, busy1;
  logic [1:0]   frame_cnt1;

  axi_stream_inf #(.DSIZE(8)) s0 ();
  axi_stream_inf #(.DSIZE(8)) m0 ();
  axi_stream_inf #(.DSIZE(8)) s1 ();
  axi_stream_inf #(.DSIZE(8)) m1 ();

  gen_common_frame_head #(.HEAD_BYTES(20), .DSIZE(8), .FRAME_CNT_W(16)) u0 (
    .clock(clock), .rst_n(rst_n), .head_data(head_data0), .head_valid(head_valid0),
    .head_ready(head_ready0), .busy(busy0), .frame_cnt(frame_cnt0),
    .cm_tb_s(s0), .cm_tb_m(m0)
  );

  gen_common_frame_head #(.HEAD_BYTES(1), .DSIZE(8), .FRAME_CNT_W(2)) u1 (
    .clock(clock), .rst_n(rst_n), .head_data(head_data1), .head_valid(head_valid1),
    .head_ready(head_ready1), .busy(busy1), .frame_cnt(frame_cnt1),
    .cm_tb_s(s1), .cm_tb_m(m1)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       pay;
    logic       first;
  } beat_t;

  typedef struct {
    logic [159:0] head;
    int           plen;
    logic [7:0]   pbase;
    bit           toggle;
    bit           pay_first;
    int           exp_cnt;
  } vec_t;

  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    popped = 0;
  int    t_first = 0;
  int    t_last = 0;
  bit    mon_en = 1'b0;
  bit    rdy_toggle = 1'b0;
  bit    prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  beat_t q0[$];
  beat_t mb;
  vec_t  vecs[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_timeout(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timeout", nm);
  endtask

  always @(posedge clock) cyc++;

  // Downstream ready: constant high or alternating 1-0-1-0
  initial begin
    m0.axis_tready = 1'b1;
    m1.axis_tready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      m0.axis_tready = rdy_toggle ? !m0.axis_tready : 1'b1;
    end
  end

  // Output monitor for the 20-byte instance, sampled on the falling edge
  always @(negedge clock) begin
    if (mon_en) begin
      if (s0.axis_tvalid && s0.axis_tready)
        check("s_tready_only_for_payload", (q0.size() > 0) ? {31'd0, q0[0].pay} : 32'd0, 32'd1);
      if (prev_stall) begin
        check("stall_valid", m0.axis_tvalid, 1);
        check("stall_data", m0.axis_tdata, prev_data);
      end
      if (m0.axis_tvalid && m0.axis_tready) begin
        if (q0.size() == 0) begin
          fail_timeout("extra_beat");
        end else begin
          mb = q0.pop_front();
          check("beat_data", m0.axis_tdata, mb.d);
          check("beat_last", m0.axis_tlast, mb.l);
          if (mb.first) t_first = cyc;
          if (mb.l) t_last = cyc;
          popped++;
        end
      end
      prev_stall = m0.axis_tvalid && !m0.axis_tready;
      prev_data  = m0.axis_tdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_frame0(input logic [159:0] h, input int plen, input logic [7:0] base);
    beat_t b;
    for (int i = 0; i < 20; i++) begin
      b.d = h[159 - 8*i -: 8];
      b.l = 1'b0;
      b.pay = 1'b0;
      b.first = (i == 0);
      q0.push_back(b);
    end
    for (int j = 0; j < plen; j++) begin
      b.d = base + 8'(j);
      b.l = (j == plen - 1);
      b.pay = 1'b1;
      b.first = 1'b0;
      q0.push_back(b);
    end
  endtask

  task automatic wait_acc0(output int c);
    c = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (head_ready0) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) fail_timeout("head_accept");
    @(posedge clock);
    #1;
  endtask

  task automatic send_head0(input logic [159:0] h);
    int c;
    head_data0 = h;
    head_valid0 = 1'b1;
    wait_acc0(c);
    head_valid0 = 1'b0;
    head_data0 = '0;
    @(negedge clock);
    check("first_beat_valid", m0.axis_tvalid, 1);
    check("first_beat_data", m0.axis_tdata, h[159:152]);
    check("head_tkeep_tuser", {m0.axis_tkeep, m0.axis_tuser}, 2'b10);
  endtask

  task automatic send_pay0(input int n, input logic [7:0] base);
    bit ok;
    for (int i = 0; i < n; i++) begin
      s0.axis_tdata = base + 8'(i);
      s0.axis_tlast = (i == n - 1);
      s0.axis_tvalid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clock);
        if (s0.axis_tready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail_timeout("payload_accept");
      @(posedge clock);
      #1;
    end
    s0.axis_tvalid = 1'b0;
    s0.axis_tlast = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    rdy_toggle = v.toggle;
    push_frame0(v.head, v.plen, v.pbase);
    fork
      send_pay0(v.plen, v.pbase);
      begin
        if (v.pay_first) begin
          repeat (5) @(posedge clock);
          #1;
        end
        send_head0(v.head);
      end
    join
    check("queue_drained", q0.size(), 0);
    check("frame_cnt", frame_cnt0, v.exp_cnt);
    check("idle_busy", busy0, 0);
    check("idle_head_ready", head_ready0, 1);
    if (!v.toggle)
      check("no_idle_cycles", t_last - t_first, 20 + v.plen - 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_b;
    int tl_a;
    int exp6[5];
    logic [7:0] hb1;
    bit done;
    int nb;
    bit acc_now;

    exp6 = '{1, 2, 3, 0, 1};
    vecs[0] = '{160'h45000054_1C460000_40010000_C0A80001_C0A80002, 4, 8'hAA, 1'b0, 1'b0, 1};
    vecs[1] = '{160'h45000054_1C460000_40010000_C0A80001_C0A80002, 4, 8'hAA, 1'b1, 1'b0, 2};
    vecs[2] = '{160'h45000054_1C460000_40010000_C0A80001_C0A80002, 4, 8'hAA, 1'b0, 1'b1, 3};
    vecs[3] = '{160'h01234567_89ABCDEF_FEDCBA98_76543210_DEADBEEF, 1, 8'h55, 1'b1, 1'b1, 4};

    rst_n = 1'b0;
    head_data0 = '0;
    head_valid0 = 1'b0;
    head_data1 = '0;
    head_valid1 = 1'b0;
    s0.axis_tdata = '0; s0.axis_tvalid = 1'b0; s0.axis_tlast = 1'b0;
    s0.axis_tkeep = 1'b1; s0.axis_tuser = 1'b0;
    s1.axis_tdata = '0; s1.axis_tvalid = 1'b0; s1.axis_tlast = 1'b0;
    s1.axis_tkeep = 1'b1; s1.axis_tuser = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_head_ready", head_ready0, 0);
    check("rst_busy", busy0, 0);
    check("rst_frame_cnt", frame_cnt0, 0);
    check("rst_m_tvalid_tlast", {m0.axis_tvalid, m0.axis_tlast}, 0);
    check("rst_s_tready", s0.axis_tready, 0);
    rst_n = 1'b1;

    // Reset while header beat 7 is on the bus: frame is dropped without tlast
    mon_en = 1'b1;
    popped = 0;
    push_frame0(vecs[0].head, 0, 8'h00);
    send_head0(vecs[0].head);
    for (int i = 0; i < 100 && popped < 7; i++) @(negedge clock);
    check("reached_beat7", popped >= 7, 1);
    rst_n = 1'b0;
    mon_en = 1'b0;
    q0.delete();
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    @(negedge clock);
    check("midrst_m_tvalid", m0.axis_tvalid, 0);
    check("midrst_tlast", m0.axis_tlast, 0);
    check("midrst_busy", busy0, 0);
    check("midrst_frame_cnt", frame_cnt0, 0);
    @(negedge clock);
    check("midrst_head_ready", head_ready0, 1);
    check("midrst_still_idle", m0.axis_tvalid, 0);
    mon_en = 1'b1;
    @(posedge clock);
    #1;

    for (int k = 0; k < 4; k++) run_vec(vecs[k]);

    // Back-to-back frames with head_valid held high across the boundary
    rdy_toggle = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    push_frame0(vecs[3].head, 4, 8'h10);
    push_frame0(vecs[0].head, 3, 8'h20);
    tl_a = 0;
    acc_b = -1;
    fork
      begin
        head_data0 = vecs[3].head;
        head_valid0 = 1'b1;
        wait_acc0(acc_b);
        head_data0 = vecs[0].head;
        wait_acc0(acc_b);
        head_valid0 = 1'b0;
      end
      begin
        send_pay0(4, 8'h10);
        tl_a = t_last;
        check("b2b_cnt_first", frame_cnt0, 5);
        send_pay0(3, 8'h20);
      end
    join
    check("b2b_accept_after_tlast", acc_b, tl_a + 1);
    check("b2b_cnt_second", frame_cnt0, 6);
    check("b2b_queue_drained", q0.size(), 0);

    // One-byte header instance, 2-bit frame counter wraps
    for (int f = 0; f < 5; f++) begin
      hb1 = 8'($urandom);
      head_data1 = hb1;
      head_valid1 = 1'b1;
      s1.axis_tdata = 8'hC0 + 8'(f);
      s1.axis_tlast = 1'b1;
      s1.axis_tvalid = 1'b1;
      nb = 0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge clock);
        acc_now = head_valid1 && head_ready1;
        if (m1.axis_tvalid) begin
          if (nb == 0) begin
            check("hb1_data", m1.axis_tdata, hb1);
            check("hb1_last_keep", {m1.axis_tlast, m1.axis_tkeep}, 2'b01);
          end else begin
            check("pay1_data", m1.axis_tdata, 8'hC0 + 8'(f));
            check("pay1_last", m1.axis_tlast, 1);
            done = 1'b1;
          end
          nb++;
        end
        @(posedge clock);
        #1;
        if (acc_now) head_valid1 = 1'b0;
        if (done) begin
          s1.axis_tvalid = 1'b0;
          s1.axis_tlast = 1'b0;
        end
      end
      if (!done) fail_timeout("hb1_frame");
      check("hb1_beats", nb, 2);
      check("frame_cnt1", frame_cnt1, exp6[f]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gen_common_frame_head.md
Name: gen_common_frame_head

Overview:
Upstream companion of the common-frame parser. Builds a frame by emitting a fixed-length header, then forwarding one payload packet, on a single AXI-stream master. The header is latched from a flat field vector through a valid/ready handshake, one header per packet. Its output feeds the common-frame parser, or any consumer expecting a header-plus-payload stream, e.g. an IPv4 header (20 bytes) followed by payload.

Parameters:
HEAD_BYTES, 20, number of header beats (DSIZE each); legal range 1..64
DSIZE, 8, beat width in bits; equals the data width of both stream interfaces
FRAME_CNT_W, 16, width of the frame counter

Ports:
clock  input  1  sole clock for the block and both stream interfaces
rst_n  input  1  synchronous active-low reset
head_data  input  HEAD_BYTES*DSIZE  header fields, packed; field 0 occupies the MSBs
head_valid  input  1  head_data valid
head_ready  output  1  header accepted when head_valid&&head_ready
busy  output  1  frame in progress (state != IDLE)
frame_cnt  output  FRAME_CNT_W  count of completed frames, wraps
cm_tb_s  axi_stream_inf.slaver  DSIZE  payload in
cm_tb_m  axi_stream_inf.master  DSIZE  framed stream out

Behaviour:
- Clock and reset: one clock (clock); reset rst_n is synchronous, active-low. Both interfaces are clocked by clock.
- Reset values: head_ready=0, busy=0, frame_cnt=0, cm_tb_m.axis_tvalid=0, axis_tlast=0, cm_tb_s.axis_tready=0, internal state=IDLE, beat counter=0.
- FSM states:
  - IDLE:
    - head_ready=1.
    - On head_valid&&head_ready: latch head_data into shift register, clear beat counter, go to HEAD.
    - Payload beats arriving in IDLE are stalled (s.tready=0).
  - HEAD:
    - m.tvalid=1 (registered); m.tdata = top DSIZE bits of shift register; m.tlast=0; s.tready=0.
    - On m.tvalid&&m.tready: shift left by DSIZE and increment counter.
    - On the beat where counter==HEAD_BYTES-1, go to BODY.
  - BODY:
    - Pass-through: m.tvalid=s.tvalid, m.tdata=s.tdata, m.tlast=s.tlast, m.tkeep/tuser forwarded, s.tready=m.tready.
    - On s.tvalid&&s.tready&&s.tlast: go to IDLE and increment frame_cnt (wraps at 2^FRAME_CNT_W).
- Header output is registered: the first header beat is valid on the cycle after head acceptance.
- Minimum frame length is HEAD_BYTES+1 beats; no idle cycles are inserted if m.tready is held high.
- Next head acceptance occurs in IDLE, one cycle after the payload tlast.
- Backpressure:
  - m.tvalid and m.tdata stay stable while m.tready=0 in HEAD.
  - In BODY, stalling follows the upstream/downstream handshake with zero added latency.
- head_valid deasserting while head_ready=0 has no effect; head_data is sampled only at acceptance.
- HEAD_BYTES=1: HEAD lasts exactly one accepted beat.
- Header beat m.tkeep is all ones; m.tuser=0.
- Reset mid-frame (any state): the next cycle is IDLE, all outputs at reset values. The partial frame is truncated, with no tlast emitted.
- aclken on the interfaces is ignored (treated as 1).

Decomposition:
- Package common_frame_pkg:
  - state enum {IDLE, HEAD, BODY}.
  - localparam function clog2-based counter width, CNT_W = $clog2(HEAD_BYTES+1).
- No sub-module; the header shift register and FSM live in a single module.

Test Plan:
1. HEAD_BYTES=20, head_data = 0x45000054_1C460000_4001_0000_C0A80001_C0A80002, payload 4 beats 0xAA..0xAD (tlast on 0xAD), m.tready=1 → 24 output beats: 45,00,00,54,…,C0,A8,00,02,AA,AB,AC,AD; tlast only on AD; frame_cnt=1.
2. Same stimulus with m.tready toggled 1-0-1-0 → identical beat sequence, no duplicates or drops, tdata stable while stalled.
3. Payload tvalid asserted before head_valid → s.tready stays 0 until the 20 header beats complete; first payload beat appears as beat 21.
4. Two back-to-back frames, head_valid held high → second head accepted on the cycle after the first tlast; frame_cnt 1 then 2; no header overlap.
5. rst_n low for 1 cycle during header beat 7 → m.tvalid=0, busy=0, head_ready=1 next cycle; frame_cnt unchanged; a subsequent frame is fully correct.
6. HEAD_BYTES=1, FRAME_CNT_W=2, five 1-beat-payload frames → each frame is 2 beats; frame_cnt sequence 1,2,3,0,1.
